// File: rtl/redun_mont_from_redun.sv
// Serial carry resolver: folds a redundant Montgomery result (NUM_WRDS words of
// WRD_BITS+1 bits) back into a plain binary value, one word per clock.
module redun_mont_from_redun #(
   parameter int WRD_BITS = 16,
   parameter int NUM_WRDS = 65,
   parameter int CNT_BITS = $clog2(NUM_WRDS)
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
   input  logic                             i_val,
   output logic                             o_rdy,
   output logic [NUM_WRDS*WRD_BITS-1:0]     o_dat,
   output logic [1:0]                       o_carry,
   output logic                             o_val,
   input  logic                             i_rdy
);

   localparam int RWD_BITS = WRD_BITS + 1;
   localparam int SUM_BITS = WRD_BITS + 2;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [WRD_BITS:0]     wrd_r [NUM_WRDS];
   logic [CNT_BITS-1:0]   cnt;
   logic [1:0]            carry;
   logic [SUM_BITS-1:0]   sum;
   logic                  accept;
   logic                  take;
   logic                  last;

   // Word plus incoming carry; the top two bits are the outgoing carry (max 2).
   function automatic logic [SUM_BITS-1:0] resolve_word(input logic [WRD_BITS:0] wrd,
                                                        input logic [1:0]        cin);
      return {1'b0, wrd} + SUM_BITS'(cin);
   endfunction

   assign o_rdy  = (state == IDLE);
   assign accept = i_val && o_rdy;
   assign take   = o_val && i_rdy;
   assign last   = (cnt == CNT_BITS'(NUM_WRDS - 1));
   assign sum    = resolve_word(wrd_r[cnt], carry);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (last)   state_nxt = DONE;
         DONE:    if (take)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Input words are captured once and only read while BUSY, so no reset needed.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int i = 0; i < NUM_WRDS; i++) begin
            wrd_r[i] <= i_dat[i*RWD_BITS +: RWD_BITS];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt     <= '0;
         carry   <= '0;
         o_dat   <= '0;
         o_carry <= '0;
         o_val   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt   <= '0;
                  carry <= '0;
               end
            end
            BUSY: begin
               o_dat[int'(cnt)*WRD_BITS +: WRD_BITS] <= sum[WRD_BITS-1:0];
               carry <= sum[SUM_BITS-1:WRD_BITS];
               cnt   <= cnt + 1'b1;
               if (last) begin
                  o_carry <= sum[SUM_BITS-1:WRD_BITS];
                  o_val   <= 1'b1;
               end
            end
            DONE: begin
               if (take) o_val <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_redun_mont_from_redun.sv
// Randomized bench for redun_mont_from_redun against a big-integer model of
// the redundant-to-binary conversion.
module tb_redun_mont_from_redun;

   localparam int WB  = 16;
   localparam int NW  = 65;
   localparam int RW  = WB + 1;
   localparam int DB  = NW * WB;
   localparam int IB  = NW * RW;

   logic          clk;
   logic          rst;
   logic [IB-1:0] i_dat;
   logic          i_val;
   logic          o_rdy;
   logic [DB-1:0] o_dat;
   logic [1:0]    o_carry;
   logic          o_val;
   logic          i_rdy;

   int n_chk;
   int n_fail;

   redun_mont_from_redun #(.WRD_BITS(WB), .NUM_WRDS(NW)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_dat   (i_dat),
      .i_val   (i_val),
      .o_rdy   (o_rdy),
      .o_dat   (o_dat),
      .o_carry (o_carry),
      .o_val   (o_val),
      .i_rdy   (i_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Value of the redundant form: sum of word_i * 2^(WB*i), kept wide enough for the carry.
   function automatic logic [DB+1:0] from_redun(input logic [IB-1:0] d);
      logic [DB+1:0] acc;
      acc = '0;
      for (int i = 0; i < NW; i++) begin
         acc = acc + ((DB+2)'(d[i*RW +: RW]) << (i*WB));
      end
      return acc;
   endfunction

   function automatic logic [IB-1:0] rand_vec(input int max_word);
      logic [IB-1:0] v;
      for (int i = 0; i < NW; i++) begin
         v[i*RW +: RW] = RW'($urandom_range(0, max_word));
      end
      return v;
   endfunction

   function automatic logic [IB-1:0] pattern_vec(input logic [RW-1:0] w0, input logic [RW-1:0] wn);
      logic [IB-1:0] v;
      for (int i = 0; i < NW; i++) begin
         v[i*RW +: RW] = (i == 0) ? w0 : wn;
      end
      return v;
   endfunction

   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      while (!o_rdy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_rdy_wait"}, 64'(o_rdy), 64'd1);
   endtask

   task automatic run_conv(input string tag, input logic [IB-1:0] d, input int hold);
      logic [DB+1:0] exp;
      int n;
      exp = from_redun(d);
      wait_rdy(tag);
      i_rdy = (hold == 0);
      i_dat = d;
      i_val = 1'b1;
      @(posedge clk); #1;
      i_val = 1'b0;
      i_dat = rand_vec(17'h1FFFF);
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         n = k;
         if (o_val) break;
      end
      check({tag, "_latency"}, 64'(n), 64'd65);
      for (int i = 0; i < NW; i++) begin
         check($sformatf("%s_w%0d", tag, i), 64'(o_dat[i*WB +: WB]), 64'(exp[i*WB +: WB]));
      end
      check({tag, "_carry"}, 64'(o_carry), 64'(exp[DB+1:DB]));
      if (hold > 0) begin
         for (int c = 0; c < hold; c++) begin
            i_val = 1'b1;
            i_dat = rand_vec(17'h1FFFF);
            @(posedge clk); #1;
            check({tag, "_hold_val"}, 64'(o_val), 64'd1);
            check({tag, "_hold_rdy"}, 64'(o_rdy), 64'd0);
            check({tag, "_hold_dat"}, 64'(o_dat == exp[DB-1:0]), 64'd1);
            check({tag, "_hold_carry"}, 64'(o_carry), 64'(exp[DB+1:DB]));
         end
         i_val = 1'b0;
         i_rdy = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, "_val_drop"}, 64'(o_val), 64'd0);
      check({tag, "_rdy_back"}, 64'(o_rdy), 64'd1);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      i_val  = 1'b0;
      i_rdy  = 1'b1;
      i_dat  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_val", 64'(o_val), 64'd0);
      check("rst_rdy", 64'(o_rdy), 64'd1);
      check("rst_carry", 64'(o_carry), 64'd0);
      check("rst_dat_zero", 64'(o_dat == '0), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 3; t++) begin
         run_conv($sformatf("rt%0d", t), rand_vec(16'hFFFF), 0);
      end
      run_conv("step", pattern_vec(17'h10000, 17'h10000), 0);
      run_conv("ripple", pattern_vec(17'h10000, 17'h0FFFF), 0);
      run_conv("max", pattern_vec(17'h1FFFF, 17'h1FFFF), 0);
      for (int t = 0; t < 3; t++) begin
         run_conv($sformatf("rnd%0d", t), rand_vec(17'h1FFFF), 0);
      end
      run_conv("bp", rand_vec(17'h1FFFF), 10);

      // Abort a conversion with reset while cnt is 30.
      wait_rdy("abort");
      i_dat = pattern_vec(17'h1FFFF, 17'h1FFFF);
      i_val = 1'b1;
      @(posedge clk); #1;
      i_val = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("abort_busy_rdy", 64'(o_rdy), 64'd0);
      rst = 1'b1;
      #1;
      check("abort_val", 64'(o_val), 64'd0);
      check("abort_rdy", 64'(o_rdy), 64'd1);
      check("abort_carry", 64'(o_carry), 64'd0);
      check("abort_dat_zero", 64'(o_dat == '0), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         if (o_val) begin
            check("abort_no_output", 64'(o_val), 64'd0);
            break;
         end
      end
      run_conv("zero", '0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/redun_mont_from_redun.md
Name: redun_mont_from_redun

Overview:
- Sequential carry-resolver that converts a Montgomery result from redundant form back to a normal binary field element, one word per cycle.
- Input form: NUM_WRDS words of WRD_BITS+1 bits. Output form: DAT_BITS-bit binary value.
- Sits between the redundant Montgomery squaring core and the msu output path; it is the inverse of the to_redun conversion at the core input.
- The serial ripple replaces a 1040-bit combinational adder chain.

Parameters:
- WRD_BITS, 16, binary bits per word; each redundant word carries one extra bit.
- NUM_WRDS, 65, number of words; DAT_BITS = NUM_WRDS*WRD_BITS = 1040.
- CNT_BITS, $clog2(NUM_WRDS), width of the word counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_dat  in  NUM_WRDS*(WRD_BITS+1)  redundant input; word i = i_dat[i*(WRD_BITS+1) +: WRD_BITS+1]
- i_val  in  1  input valid
- o_rdy  out 1  input ready
- o_dat  out NUM_WRDS*WRD_BITS  normalized binary result
- o_carry out 2  final carry beyond bit DAT_BITS-1
- o_val  out 1  output valid
- i_rdy  in  1  downstream ready

Behaviour:
- Reset: state=IDLE, cnt=0, carry=0, o_dat=0, o_carry=0, o_val=0, o_rdy=1. Reset asserted mid-operation aborts the conversion immediately; no output is produced for it.
- States:
  - IDLE: o_rdy=1, o_val=0. On i_val&&o_rdy at an edge: capture i_dat into the word register, clear carry and cnt, go to BUSY.
  - BUSY: o_rdy=0. Each edge: sum = word[cnt] + carry (18 bits); o_dat[cnt*WRD_BITS +: WRD_BITS] <= sum[WRD_BITS-1:0]; carry <= sum>>WRD_BITS; cnt++.
    - carry is 2 bits. Max sum is 0x1FFFF+2, so carry is at most 2 and never overflows.
    - On the edge processing cnt==NUM_WRDS-1: o_carry <= final carry, o_val <= 1, go to DONE.
  - DONE: o_val=1; o_dat and o_carry are held stable while i_rdy=0. On o_val&&i_rdy: o_val <= 0, go to IDLE.
- Latency: o_val rises exactly NUM_WRDS (65) edges after the accept edge.
- Throughput: one conversion per NUM_WRDS+2 cycles. A new input is never accepted in the same cycle that the output is taken.
- i_dat is don't-care outside the accept edge; it is registered on accept.
- o_dat words not yet written in the current conversion hold prior values. o_dat is only meaningful while o_val=1.
- The result equals from_redun(i_dat) mod 2^DAT_BITS. o_carry equals from_redun(i_dat) >> DAT_BITS, which is in 0..2.
- No modular reduction is performed; downstream handles a nonzero o_carry.
- i_val while o_rdy=0 is ignored and must be held by upstream.

Test Plan:
- Round-trip: i_dat=to_redun(P) with top bits 0 -> o_dat==P, o_carry=0; o_val rises exactly 65 edges after accept.
- Single-step carries: all words 0x10000 -> o_dat word0=0x0000, words 1..64=0x0001, o_carry=1.
- Full ripple: word0=0x10000, words 1..64=0xFFFF -> o_dat=0, o_carry=1.
- Max input: all words 0x1FFFF -> word0=0xFFFF, word1=0x0000, words 2..64=0x0001, o_carry=2.
- Back-pressure: hold i_rdy=0 for 10 cycles after o_val -> o_dat/o_carry stable, o_rdy=0, extra i_val ignored. Release i_rdy -> o_val drops next edge, o_rdy=1 following cycle.
- Reset mid-BUSY: pulse i_rst at cnt=30 -> outputs return to reset values immediately. A subsequent all-zero input -> o_dat=0, o_carry=0 after 65 edges.
